sim_ctrl_slave: RTL and testbench
=================================

# sim_ctrl_slave

Simulation-control bus slave for the single-core testbench. It sits on the SoC bus next to the memory and print slaves and consumes bus transactions issued by the or1420 SoC. Software uses it to report pass/fail, which raises `sim_done_o` for the harness to end the run. It also exposes a free-running 64-bit cycle counter, a scratch register and an ID word for timing and bus sanity checks.

## Interface
- `baseAddr`, 32'h50000000, window base; 256-byte window, decode on `bus_addrData_i[31:8] == baseAddr[31:8]`
- `idValue`, 32'h51C00001, constant returned at offset 0x10
- `clk_i` in 1: system clock, single clock domain
- `rst_ni` in 1: reset, asynchronous, active-low
- `bus_addrData_i` in 32: address on begin cycle, write data on data beats
- `bus_byteEnables_i` in 4: byte lanes for writes
- `bus_burstSize_i` in 8: beats minus one
- `bus_readNWrite_i` in 1: 1 = read
- `bus_beginTransaction_i` in 1: transaction start strobe
- `bus_endTransaction_i` in 1: master end of write transaction
- `bus_dataValid_i` in 1: write data beat valid
- `bus_busy_i` in 1: master stall; slave holds read beats while high
- `bus_addrData_o` out 32: read data, 0 when not driving
- `bus_endTransaction_o` out 1: slave end of read or error
- `bus_dataValid_o` out 1: read beat valid
- `bus_busy_o` out 1: always 0, slave never stalls
- `bus_error_o` out 1: unmapped start offset
- `sim_done_o` out 1: sticky, software reported completion
- `exit_code_o` out 8: exit code from software

## Operation
- Register map, word offsets:
  - 0x00 EXIT (W; reads return {done,23'b0,code}). Bit 31 = done, bits [7:0] = code.
  - 0x04 CYCLE_LO (R). The read latches CYCLE[63:32] into a shadow register.
  - 0x08 CYCLE_HI (R). Returns the shadow value.
  - 0x0C SCRATCH (RW, per-byte enables).
  - 0x10 ID (R).
- Writes to read-only offsets are ignored.
- FSM states: IDLE, WRITE, READ_ADDR, READ_DATA, READ_END, ERR.
  - IDLE: begin with address in window and offset <= 0x10 → WRITE or READ_ADDR. Start offset 0x14–0xFC → ERR. Out of window → ignore.
  - WRITE: each `bus_dataValid_i` beat writes the current offset, then offset += 4. `bus_endTransaction_i` → IDLE.
  - READ_ADDR: one idle cycle → READ_DATA.
  - READ_DATA: drives one beat per cycle while `bus_busy_i` = 0, offset += 4 per beat. After burstSize+1 beats → READ_END.
  - READ_END: `bus_endTransaction_o` = 1 for one cycle → IDLE.
  - ERR: `bus_error_o` = 1 and `bus_endTransaction_o` = 1 for one cycle. For writes, it then waits in ERR, silent, for `bus_endTransaction_i` before returning to IDLE.
- Burst offsets past 0x10 read 0; writes to them are dropped without error. The offset counter is 8 bits and wraps within the window.
- EXIT write with byteEnable[3] and data bit 31 = 1 sets `sim_done_o` (sticky). Lane 0 updates `exit_code_o`.
- Cycle counter: 64-bit, +1 every cycle after reset. It freezes from the cycle after `sim_done_o` rises.
- `bus_beginTransaction_i` while not in IDLE is ignored.

## Timing
- Reset values: all outputs 0; counter, shadow and SCRATCH are 0; FSM in IDLE.
- Reset asserted mid-transaction aborts it immediately. No `bus_endTransaction_o` is issued.
- Read with begin at cycle T: first `bus_dataValid_o` at T+2. The last beat is at T+2+burstSize when unstalled. `bus_endTransaction_o` follows one cycle after the last beat.
- A beat held by `bus_busy_i` keeps its data and offset stable. `bus_dataValid_o` is deasserted while held.
- CYCLE_LO value equals the counter value at the data-drive cycle.
- Error: begin at T → `bus_error_o` and `bus_endTransaction_o` at T+1.
- Write beat at cycle T is visible to a read from T+1 onward. `sim_done_o` rises at T+1.
- Write `bus_dataValid_i` together with `bus_endTransaction_i`: the beat is written, then the FSM returns to IDLE.

## Test plan
- Reset, then single read of 0x50000010 → data 0x51C00001 at T+2, end at T+3, `bus_error_o` = 0.
- Write SCRATCH 0xDEADBEEF with byteEnables 4'b0101, starting from 0 → read returns 0x00AD00EF.
- Burst read of 5 beats from 0x00, with `bus_busy_i` high on beat 3 for 2 cycles → beats EXIT, LO, HI, SCRATCH, ID in order. HI equals the counter bits [63:32] captured at the LO read. End comes 1 cycle after the 5th beat.
- Write 0x8000002A to EXIT → `sim_done_o` = 1 and `exit_code_o` = 0x2A next cycle. Two later CYCLE_LO reads return equal values.
- Read at 0x50000020 → error plus end at T+1. Write at 0x50000040 with 2 beats → error pulse, no register change, back to IDLE after the master end.
- `rst_ni` low during READ_DATA beat 2 → all outputs 0 asynchronously. After release, a fresh read succeeds.

Source files
------------

// File: rtl/sim_ctrl_slave.sv
// Simulation-control bus slave: exit/done reporting, free-running 64-bit cycle
// counter with high-word shadow, byte-writable scratch and a constant ID word.
//
// state        | meaning
// ST_IDLE      | waiting for a transaction start inside the window
// ST_WRITE     | accepting write beats until the master ends the transaction
// ST_READ_ADDR | one turnaround cycle, first read beat is fetched
// ST_READ_DATA | presenting read beats, held while the master is busy
// ST_READ_END  | slave end-of-transaction pulse after the last read beat
// ST_ERR       | error + end pulse; write errors then wait for the master end
module sim_ctrl_slave #(
    parameter logic [31:0] baseAddr = 32'h5000_0000,
    parameter logic [31:0] idValue  = 32'h51C0_0001
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] bus_addrData_i,
    input  logic [3:0]  bus_byteEnables_i,
    input  logic [7:0]  bus_burstSize_i,
    input  logic        bus_readNWrite_i,
    input  logic        bus_beginTransaction_i,
    input  logic        bus_endTransaction_i,
    input  logic        bus_dataValid_i,
    input  logic        bus_busy_i,
    output logic [31:0] bus_addrData_o,
    output logic        bus_endTransaction_o,
    output logic        bus_dataValid_o,
    output logic        bus_busy_o,
    output logic        bus_error_o,
    output logic        sim_done_o,
    output logic [7:0]  exit_code_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_ADDR,
        ST_READ_DATA,
        ST_READ_END,
        ST_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  offset_q, offset_d;
    logic [7:0]  beats_q, beats_d;
    logic        wr_err_q, wr_err_d;
    logic [63:0] cycle_q, cycle_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] scratch_q, scratch_d;
    logic        done_q, done_d;
    logic [7:0]  code_q, code_d;
    logic [31:0] rdata_q, rdata_d;
    logic        end_q, end_d;
    logic        err_q, err_d;

    logic        in_win;
    logic [7:0]  rd_off;
    logic [31:0] rd_val;
    logic        rd_load;

    assign in_win = (bus_addrData_i[31:8] == baseAddr[31:8]);
    // READ_ADDR fetches the start offset; each accepted beat prefetches the next one.
    assign rd_off = (state_q == ST_READ_ADDR) ? offset_q : offset_q + 8'd4;

    always_comb begin
        cycle_d = done_q ? cycle_q : cycle_q + 64'd1;
        case (rd_off)
            8'h00:   rd_val = {done_q, 23'd0, code_q};
            8'h04:   rd_val = cycle_d[31:0];
            8'h08:   rd_val = shadow_q;
            8'h0C:   rd_val = scratch_q;
            8'h10:   rd_val = idValue;
            default: rd_val = 32'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        beats_d   = beats_q;
        wr_err_d  = wr_err_q;
        shadow_d  = shadow_q;
        scratch_d = scratch_q;
        done_d    = done_q;
        code_d    = code_q;
        rdata_d   = rdata_q;
        end_d     = 1'b0;
        err_d     = 1'b0;
        rd_load   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus_beginTransaction_i && in_win) begin
                    offset_d = bus_addrData_i[7:0];
                    beats_d  = bus_burstSize_i;
                    wr_err_d = ~bus_readNWrite_i;
                    if (bus_addrData_i[7:0] <= 8'h10) begin
                        state_d = bus_readNWrite_i ? ST_READ_ADDR : ST_WRITE;
                    end else begin
                        state_d = ST_ERR;
                        end_d   = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (bus_dataValid_i) begin
                    case (offset_q)
                        8'h00: begin
                            if (bus_byteEnables_i[3] && bus_addrData_i[31]) done_d = 1'b1;
                            if (bus_byteEnables_i[0]) code_d = bus_addrData_i[7:0];
                        end
                        8'h0C: begin
                            for (int i = 0; i < 4; i++) begin
                                if (bus_byteEnables_i[i]) scratch_d[8*i +: 8] = bus_addrData_i[8*i +: 8];
                            end
                        end
                        default: ;
                    endcase
                    offset_d = offset_q + 8'd4;
                end
                if (bus_endTransaction_i) state_d = ST_IDLE;
            end
            ST_READ_ADDR: begin
                state_d = ST_READ_DATA;
                rd_load = 1'b1;
            end
            ST_READ_DATA: begin
                if (!bus_busy_i) begin
                    if (beats_q == 8'd0) begin
                        state_d = ST_READ_END;
                        end_d   = 1'b1;
                    end else begin
                        beats_d  = beats_q - 8'd1;
                        offset_d = offset_q + 8'd4;
                        rd_load  = 1'b1;
                    end
                end
            end
            ST_READ_END: state_d = ST_IDLE;
            ST_ERR: begin
                if (!wr_err_q || bus_endTransaction_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd_load) begin
            rdata_d = rd_val;
            // Reading CYCLE_LO snapshots the high word so a later HI read is coherent.
            if (rd_off == 8'h04) shadow_d = cycle_d[63:32];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            offset_q  <= 8'd0;
            beats_q   <= 8'd0;
            wr_err_q  <= 1'b0;
            cycle_q   <= 64'd0;
            shadow_q  <= 32'd0;
            scratch_q <= 32'd0;
            done_q    <= 1'b0;
            code_q    <= 8'd0;
            rdata_q   <= 32'd0;
            end_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            beats_q   <= beats_d;
            wr_err_q  <= wr_err_d;
            cycle_q   <= cycle_d;
            shadow_q  <= shadow_d;
            scratch_q <= scratch_d;
            done_q    <= done_d;
            code_q    <= code_d;
            rdata_q   <= rdata_d;
            end_q     <= end_d;
            err_q     <= err_d;
        end
    end

    assign bus_dataValid_o      = (state_q == ST_READ_DATA) && !bus_busy_i;
    assign bus_addrData_o       = bus_dataValid_o ? rdata_q : 32'd0;
    assign bus_endTransaction_o = end_q;
    assign bus_error_o          = err_q;
    assign bus_busy_o           = 1'b0;
    assign sim_done_o           = done_q;
    assign exit_code_o          = code_q;

endmodule

// File: tb/tb_sim_ctrl_slave.sv
// Bench for sim_ctrl_slave: directed table, busy/reset/done corner sequences
// and random bursts checked against a register-level model of the slave.
module tb_sim_ctrl_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr_data_i;
    logic [3:0]  be_i;
    logic [7:0]  burst_i;
    logic        rnw_i, begin_i, end_i, dv_i, busy_i;
    logic [31:0] addr_data_o;
    logic        end_o, dv_o, busy_o, err_o, done_o;
    logic [7:0]  code_o;

    sim_ctrl_slave dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .bus_addrData_i         (addr_data_i),
        .bus_byteEnables_i      (be_i),
        .bus_burstSize_i        (burst_i),
        .bus_readNWrite_i       (rnw_i),
        .bus_beginTransaction_i (begin_i),
        .bus_endTransaction_i   (end_i),
        .bus_dataValid_i        (dv_i),
        .bus_busy_i             (busy_i),
        .bus_addrData_o         (addr_data_o),
        .bus_endTransaction_o   (end_o),
        .bus_dataValid_o        (dv_o),
        .bus_busy_o             (busy_o),
        .bus_error_o            (err_o),
        .sim_done_o             (done_o),
        .exit_code_o            (code_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Elapsed clock edges since reset release: what the counter reads unless frozen.
    logic [63:0] cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 64'd0;
        else        cyc <= cyc + 64'd1;
    end

    bit          m_done;
    logic [7:0]  m_code;
    logic [31:0] m_scratch;
    logic [31:0] m_shadow;
    logic [63:0] m_freeze;

    function automatic void model_reset();
        m_done = 0; m_code = 8'd0; m_scratch = 32'd0; m_shadow = 32'd0; m_freeze = 64'd0;
    endfunction

    function automatic logic [63:0] exp_count();
        return m_done ? m_freeze : cyc;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] off);
        logic [63:0] cnt;
        case (off)
            8'h00: return {m_done, 23'd0, m_code};
            8'h04: begin
                cnt = exp_count();
                m_shadow = cnt[63:32];
                return cnt[31:0];
            end
            8'h08: return m_shadow;
            8'h0C: return m_scratch;
            8'h10: return 32'h51C0_0001;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] be);
        if (off == 8'h00) begin
            // Done becomes visible next cycle, counter stops the cycle after that.
            if (be[3] && d[31] && !m_done) begin m_done = 1; m_freeze = cyc + 64'd1; end
            if (be[0]) m_code = d[7:0];
        end else if (off == 8'h0C) begin
            for (int i = 0; i < 4; i++) if (be[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        addr_data_i = 32'd0; be_i = 4'd0; burst_i = 8'd0; rnw_i = 1'b0;
        begin_i = 1'b0; end_i = 1'b0; dv_i = 1'b0; busy_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input int nbeats, input bit exp_err,
                            input int stall_beat, input int stall_len, output logic [31:0] first_data);
        logic [7:0]  off;
        logic [31:0] exp_d;
        int          beat, held;
        bit          fresh, busy;
        first_data = 32'd0;
        @(negedge clk); clear_inputs();
        begin_i = 1'b1; addr_data_i = addr; rnw_i = 1'b1; burst_i = 8'(nbeats - 1);
        @(negedge clk); clear_inputs(); #1;
        check("rd_err_t1", err_o, exp_err);
        check("rd_end_t1", end_o, exp_err);
        check("rd_valid_t1", dv_o, 0);
        if (exp_err) begin
            @(negedge clk); #1;
            check("rd_err_pulse", err_o, 0);
            return;
        end
        off = addr[7:0]; beat = 0; held = 0; fresh = 1;
        while (beat < nbeats) begin
            @(negedge clk);
            if (fresh) begin exp_d = model_read(off); fresh = 0; held = 0; end
            busy = (beat == stall_beat) && (held < stall_len);
            busy_i = busy; #1;
            check("rd_end_in_burst", end_o, 0);
            if (busy) begin
                check("rd_held_valid", dv_o, 0);
                check("rd_held_data", addr_data_o, 0);
                held++;
            end else begin
                check("rd_valid", dv_o, 1);
                check("rd_data", addr_data_o, exp_d);
                if (beat == 0) first_data = addr_data_o;
                beat++; off = off + 8'd4; fresh = 1;
            end
        end
        @(negedge clk); busy_i = 1'b0; #1;
        check("rd_end", end_o, 1);
        check("rd_end_valid", dv_o, 0);
        @(negedge clk); #1;
        check("rd_end_pulse", end_o, 0);
    endtask

    task automatic bus_write(input logic [31:0] addr, input int nbeats, input logic [31:0] d0,
                             input logic [3:0] be, input bit exp_err, input bit allow_done);
        logic [7:0]  off;
        logic [31:0] d;
        off = addr[7:0];
        @(negedge clk); clear_inputs();
        begin_i = 1'b1; addr_data_i = addr; rnw_i = 1'b0; burst_i = 8'(nbeats - 1);
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk); clear_inputs();
            d = d0 + 32'(i) * 32'h0101_0101;
            if (off == 8'h00 && !allow_done) d[31] = 1'b0;
            addr_data_i = d; be_i = be; dv_i = 1'b1; end_i = (i == nbeats - 1); #1;
            if (i == 0) begin
                check("wr_err_t1", err_o, exp_err);
                check("wr_end_t1", end_o, exp_err);
            end
            if (!exp_err) model_write(off, d, be);
            off = off + 8'd4;
        end
        @(negedge clk); clear_inputs(); #1;
        check("wr_err_after", err_o, 0);
        check("wr_end_after", end_o, 0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          beats;
        bit          err;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          nb;
        clear_inputs();
        model_reset();
        tbl[0]  = '{0, 32'h5000_0010, 32'h0,         4'h0, 1, 0, 32'h51C0_0001};
        tbl[1]  = '{1, 32'h5000_000C, 32'hDEAD_BEEF, 4'h5, 1, 0, 32'h0};
        tbl[2]  = '{0, 32'h5000_000C, 32'h0,         4'h0, 1, 0, 32'h00AD_00EF};
        tbl[3]  = '{1, 32'h5000_000C, 32'h1234_5678, 4'hA, 1, 0, 32'h0};
        tbl[4]  = '{0, 32'h5000_000C, 32'h0,         4'h0, 1, 0, 32'h12AD_56EF};
        tbl[5]  = '{1, 32'h5000_0010, 32'hFFFF_FFFF, 4'hF, 1, 0, 32'h0};
        tbl[6]  = '{0, 32'h5000_0010, 32'h0,         4'h0, 1, 0, 32'h51C0_0001};
        tbl[7]  = '{0, 32'h5000_0020, 32'h0,         4'h0, 1, 1, 32'h0};
        tbl[8]  = '{1, 32'h5000_0040, 32'hFFFF_FFFF, 4'hF, 2, 1, 32'h0};
        tbl[9]  = '{0, 32'h5000_000C, 32'h0,         4'h0, 1, 0, 32'h12AD_56EF};
        tbl[10] = '{0, 32'h5000_0000, 32'h0,         4'h0, 1, 0, 32'h0000_0000};
        tbl[11] = '{0, 32'h5000_0014, 32'h0,         4'h0, 1, 1, 32'h0};
        tbl[12] = '{1, 32'h5000_0000, 32'h0000_0055, 4'h1, 1, 0, 32'h0};
        tbl[13] = '{0, 32'h5000_0000, 32'h0,         4'h0, 1, 0, 32'h0000_0055};

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_data", addr_data_o, 0);
        check("rst_valid", dv_o, 0);
        check("rst_end", end_o, 0);
        check("rst_err", err_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_code", code_o, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) begin
                bus_write(tbl[i].addr, tbl[i].beats, tbl[i].data, tbl[i].be, tbl[i].err, 1);
            end else begin
                bus_read(tbl[i].addr, tbl[i].beats, tbl[i].err, -1, 0, rd);
                if (!tbl[i].err) check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp);
            end
        end

        // Out-of-window begin must be ignored entirely.
        @(negedge clk); clear_inputs();
        begin_i = 1'b1; addr_data_i = 32'h6000_0000; rnw_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); clear_inputs(); #1;
            check("oow_quiet", {dv_o, end_o, err_o}, 3'b000);
        end

        bus_read(32'h5000_0000, 5, 0, 2, 2, rd);
        bus_read(32'h5000_0008, 4, 0, 0, 1, rd);

        for (int t = 0; t < 60; t++) begin
            bit is_err;
            is_err = ($urandom_range(0, 9) == 0);
            if (is_err) a = 32'h5000_0014 + 32'(4 * $urandom_range(0, 58));
            else        a = 32'h5000_0000 + 32'(4 * $urandom_range(0, 4));
            nb = $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 1)
                bus_read(a, nb, is_err, $urandom_range(0, nb - 1), $urandom_range(0, 2), rd);
            else
                bus_write(a, nb, $urandom, 4'($urandom_range(0, 15)), is_err, 0);
        end

        check("pre_done", done_o, 0);
        bus_write(32'h5000_0000, 1, 32'h8000_002A, 4'hF, 0, 1);
        check("done_set", done_o, 1);
        check("exit_code", code_o, 8'h2A);
        bus_read(32'h5000_0004, 1, 0, -1, 0, rd);
        repeat (3) @(negedge clk);
        bus_read(32'h5000_0004, 1, 0, -1, 0, rd);
        bus_read(32'h5000_0000, 3, 0, -1, 0, rd);
        check("exit_rd", rd, 32'h8000_002A);

        // Reset lands while the third beat of a burst is on the bus.
        @(negedge clk); clear_inputs();
        begin_i = 1'b1; addr_data_i = 32'h5000_0000; rnw_i = 1'b1; burst_i = 8'd3;
        repeat (3) @(negedge clk);
        clear_inputs();
        @(negedge clk); #1;
        check("mid_valid", dv_o, 1);
        rst_n = 1'b0; #1;
        model_reset();
        check("arst_data", addr_data_o, 0);
        check("arst_valid", dv_o, 0);
        check("arst_end", end_o, 0);
        check("arst_done", done_o, 0);
        check("arst_code", code_o, 0);
        @(negedge clk); #1;
        check("arst_end_hold", end_o, 0);
        rst_n = 1'b1;
        bus_read(32'h5000_0010, 1, 0, -1, 0, rd);
        check("post_rst_id", rd, 32'h51C0_0001);
        bus_read(32'h5000_0004, 2, 0, -1, 0, rd);
        bus_read(32'h5000_000C, 1, 0, -1, 0, rd);
        check("post_rst_scratch", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
